// File: rtl/rb_bank.sv
// rb_bank: double-buffered neuron weight/bias/sign register bank.
// Single and burst writes land in the shadow copy; commit copies shadow to the active outputs.
module rb_bank #(
  parameter int DW = 8,
  parameter int NCH = 4,
  parameter int NW = 4,
  localparam int DEPTH = NCH * (NW + 2),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 burst_start,
  input  logic [AW-1:0]        burst_addr,
  input  logic [AW:0]          burst_len,
  input  logic                 commit,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NCH*NW*DW-1:0] win,
  output logic [NCH*DW-1:0]    bias,
  output logic [NCH-1:0]       sign
);
  localparam logic [1:0] S_IDLE = 2'd0, S_BURST = 2'd1, S_COMMIT = 2'd2;
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic [1:0] r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0] r_cnt;
  logic r_pend, r_done, r_err;
  logic [DW-1:0] r_sh_w [NCH*NW];
  logic [DW-1:0] r_ac_w [NCH*NW];
  logic [DW-1:0] r_sh_b [NCH];
  logic [DW-1:0] r_ac_b [NCH];
  logic [NCH-1:0] r_sh_s, r_ac_s;
  logic w_idle, w_burst, w_acc, w_ok, w_err, w_copy;
  logic [AW-1:0] w_waddr;
  logic [DEPTH-1:0] w_we;

  assign w_idle = r_state == S_IDLE;
  assign w_burst = r_state == S_BURST;
  assign wr_ready = !rst && (w_idle ? en && !burst_start && !commit : w_burst && en);
  assign w_acc = wr_valid && wr_ready;
  assign w_ok = burst_len != '0 && burst_len <= LIM && {1'b0, burst_addr} < LIM;
  assign w_err = w_idle && (burst_start ? !w_ok : w_acc && {1'b0, wr_addr} >= LIM);
  assign w_waddr = w_burst ? r_ptr : wr_addr;
  // An IDLE commit copies on entry; a commit deferred by a burst copies inside COMMIT so the last beat is included.
  assign w_copy = (w_idle && !burst_start && (commit || r_pend)) || (r_state == S_COMMIT && r_pend);

  genvar a, c, w;
  for (a = 0; a < DEPTH; a++) begin : g_we
    assign w_we[a] = w_acc && w_waddr == AW'(a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      r_pend <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err <= w_err || (r_err && !err_clr);
      if (w_idle) begin
        if (burst_start) begin
          if (w_ok) begin
            r_state <= S_BURST;
            r_ptr <= burst_addr;
            r_cnt <= burst_len;
          end
          r_pend <= r_pend || commit;
        end else if (commit || r_pend) begin
          r_state <= S_COMMIT;
          r_pend <= 1'b0;
        end
      end else if (w_burst) begin
        if (commit) r_pend <= 1'b1;
        if (w_acc) begin
          r_ptr <= r_ptr == AW'(DEPTH - 1) ? '0 : r_ptr + AW'(1);
          r_cnt <= r_cnt - (AW+1)'(1);
          if (r_cnt == (AW+1)'(1)) begin
            r_done <= 1'b1;
            r_state <= (r_pend || commit) ? S_COMMIT : S_IDLE;
          end
        end
      end else begin
        r_state <= S_IDLE;
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH * NW; i++) begin
        r_sh_w[i] <= '0;
        r_ac_w[i] <= '0;
      end
      for (int i = 0; i < NCH; i++) begin
        r_sh_b[i] <= '0;
        r_ac_b[i] <= '0;
      end
      r_sh_s <= '0;
      r_ac_s <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < NW; j++)
          if (w_we[i*(NW+2)+j]) r_sh_w[i*NW+j] <= wr_data;
        if (w_we[i*(NW+2)+NW]) r_sh_b[i] <= wr_data;
        if (w_we[i*(NW+2)+NW+1]) r_sh_s[i] <= wr_data[0];
      end
      if (w_copy) begin
        r_ac_w <= r_sh_w;
        r_ac_b <= r_sh_b;
        r_ac_s <= r_sh_s;
      end
    end
  end

  for (c = 0; c < NCH; c++) begin : g_ch
    for (w = 0; w < NW; w++) begin : g_w
      assign win[(c*NW+w)*DW +: DW] = r_ac_w[c*NW+w];
    end
    assign bias[c*DW +: DW] = r_ac_b[c];
  end
  assign sign = r_ac_s;
  assign busy = !w_idle;
  assign done = r_done;
  assign err = r_err;
endmodule

// File: tb/tb_rb_bank.sv
// tb_rb_bank: directed vector table plus a mid-burst reset sequence for rb_bank (default parameters).
module tb_rb_bank;
  logic clk = 1'b0, rst = 1'b1;
  logic en = 1'b0, wr_valid = 1'b0, burst_start = 1'b0, commit = 1'b0, err_clr = 1'b0;
  logic [4:0] wr_addr = '0, burst_addr = '0;
  logic [7:0] wr_data = '0;
  logic [5:0] burst_len = '0;
  logic wr_ready, busy, done, err;
  logic [127:0] win;
  logic [31:0] bias;
  logic [3:0] sign;
  int checks = 0, errors = 0;

  rb_bank dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .burst_start(burst_start),
    .burst_addr(burst_addr), .burst_len(burst_len), .commit(commit),
    .err_clr(err_clr), .busy(busy), .done(done), .err(err),
    .win(win), .bias(bias), .sign(sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, v; logic [4:0] a; logic [7:0] d;
    logic bs; logic [4:0] ba; logic [5:0] bl; logic cm, ec;
    logic rdy, busy, done, err; logic [127:0] win; logic [31:0] bias; logic [3:0] sign;
  } vec_t;

  localparam logic [127:0] WA = 128'h5A_0000_0000;
  localparam logic [127:0] WB = 128'h5A_0000_0403;
  localparam logic [127:0] WC = 128'h5A_0000_0411;
  localparam logic [31:0] B1 = 32'h0100_0000;

  vec_t tv [$];

  function automatic vec_t mk(logic e, logic v, int a, int d, logic bs, int ba, int bl, logic cm, logic ec,
                              logic rdy, logic by, logic dn, logic er,
                              logic [127:0] wi, logic [31:0] bi, logic [3:0] sg);
    vec_t t;
    t.en = e; t.v = v; t.a = 5'(a); t.d = 8'(d); t.bs = bs; t.ba = 5'(ba); t.bl = 6'(bl);
    t.cm = cm; t.ec = ec; t.rdy = rdy; t.busy = by; t.done = dn; t.err = er;
    t.win = wi; t.bias = bi; t.sign = sg;
    return t;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic e, logic v, logic [4:0] a, logic [7:0] d, logic bs,
                       logic [4:0] ba, logic [5:0] bl, logic cm, logic ec);
    en = e; wr_valid = v; wr_addr = a; wr_data = d; burst_start = bs;
    burst_addr = ba; burst_len = bl; commit = cm; err_clr = ec;
  endtask

  task automatic check_outs(string tag, logic by, logic dn, logic er,
                            logic [127:0] wi, logic [31:0] bi, logic [3:0] sg);
    check({tag, " busy"}, 128'(busy), 128'(by));
    check({tag, " done"}, 128'(done), 128'(dn));
    check({tag, " err"}, 128'(err), 128'(er));
    check({tag, " win"}, win, wi);
    check({tag, " bias"}, 128'(bias), 128'(bi));
    check({tag, " sign"}, 128'(sign), 128'(sg));
  endtask

  initial begin
    //          en v  a   d     bs ba bl cm ec   rdy by dn er  win bias sign
    tv.push_back(mk(1,1, 6,'h5A, 0, 0, 0,0,0,    1, 0,0,0,  0,  0, 0));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,1,0,    0, 1,0,0,  WA, 0, 0));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,0,    0, 0,0,0,  WA, 0, 0));
    tv.push_back(mk(1,1, 5,'hFF, 0, 0, 0,0,0,    1, 0,0,0,  WA, 0, 0));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,1,0,    0, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,0,    0, 0,0,0,  WA, 0, 1));
    tv.push_back(mk(1,1,24,'h77, 0, 0, 0,0,0,    1, 0,0,1,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,1,    1, 0,0,0,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    1, 0, 0,0,0,    0, 0,0,1,  WA, 0, 1));
    tv.push_back(mk(1,1,30,1,    0, 0, 0,0,1,    1, 0,0,1,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,1,    1, 0,0,0,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    1, 0,25,0,0,    0, 0,0,1,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,1,    1, 0,0,0,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    1,22, 4,0,0,    0, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(1,1, 3,1,    0, 0, 0,0,0,    1, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(1,1, 3,2,    0, 0, 0,1,0,    1, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(0,1, 3,9,    0, 0, 0,0,0,    0, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(1,1, 3,3,    1, 0, 1,0,0,    1, 1,0,0,  WA, 0, 1));
    tv.push_back(mk(1,1, 3,4,    0, 0, 0,0,0,    1, 1,1,0,  WA, 0, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,0,    0, 0,0,0,  WB, B1, 1));
    tv.push_back(mk(1,0, 0,0,    1, 0, 1,1,0,    0, 1,0,0,  WB, B1, 1));
    tv.push_back(mk(1,1, 7,'h11, 0, 0, 0,0,0,    1, 1,1,0,  WB, B1, 1));
    tv.push_back(mk(1,0, 0,0,    0, 0, 0,0,0,    0, 0,0,0,  WC, B1, 1));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset wr_ready", 128'(wr_ready), 128'(0));
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].en, tv[i].v, tv[i].a, tv[i].d, tv[i].bs, tv[i].ba, tv[i].bl, tv[i].cm, tv[i].ec);
      #1;
      check($sformatf("v%0d wr_ready", i), 128'(wr_ready), 128'(tv[i].rdy));
      @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), tv[i].busy, tv[i].done, tv[i].err, tv[i].win, tv[i].bias, tv[i].sign);
    end

    // Reset after two of four beats, then a fresh burst and commit
    drive(1, 0, 0, 0, 1, 8, 4, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(1, 1, 0, 'hAA, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(1, 1, 0, 'hBB, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    check("midburst busy", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("rst wr_ready", 128'(wr_ready), 128'(0));
    check_outs("rst mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
    @(posedge clk); @(negedge clk);
    check("post-rst burst busy", 128'(busy), 128'(1));
    drive(1, 1, 0, 'h33, 0, 0, 0, 0, 0);
    #1 check("post-rst wr_ready", 128'(wr_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    check_outs("post-rst beat", 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); @(negedge clk);
    check_outs("post-rst commit", 1, 0, 0, 128'h33, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    check_outs("post-rst idle", 0, 0, 0, 128'h33, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rb_bank.md
RB_BANK -- requirements
Module: rb_bank

Interface
REQ-001 SHALL have parameter DW, default 8, data and register width.
REQ-002 SHALL have parameter NCH, default 4, neuron channel count.
REQ-003 SHALL have parameter NW, default 4, weights per channel; DEPTH = NCH*(NW+2), AW = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, global write enable; when low, no beat is accepted.
REQ-007 SHALL have port wr_valid, input, 1, write beat valid.
REQ-008 SHALL have port wr_ready, output, 1, beat accepted when wr_valid && wr_ready.
REQ-009 SHALL have port wr_addr, input, AW, single-write address, used in IDLE only.
REQ-010 SHALL have port wr_data, input, DW, beat data.
REQ-011 SHALL have port burst_start, input, 1, burst request pulse.
REQ-012 SHALL have port burst_addr, input, AW, burst start address.
REQ-013 SHALL have port burst_len, input, AW+1, beat count, legal range 1..DEPTH.
REQ-014 SHALL have port commit, input, 1, shadow-to-active copy request.
REQ-015 SHALL have port err_clr, input, 1, clears err.
REQ-016 SHALL have ports busy, done and err, each an output of width 1.
REQ-017 SHALL have ports win (output, NCH*NW*DW), bias (output, NCH*DW) and sign (output, NCH), all active registers, flattened with channel 0 in the LSBs.

Function
REQ-018 SHALL map address a as ch = a/(NW+2) and slot = a%(NW+2): slot 0..NW-1 is weight, slot NW is bias, slot NW+1 is sign (stores wr_data[0] only).
REQ-019 SHALL write every accepted beat into a shadow copy only; outputs SHALL show the active copy.
REQ-020 SHALL implement FSM states IDLE, BURST and COMMIT; busy = (state != IDLE).
REQ-021 In IDLE: wr_ready = en && !burst_start && !commit; an accepted beat writes shadow[wr_addr].
REQ-022 In IDLE with wr_addr >= DEPTH: the beat SHALL be accepted, dropped, and SHALL set err.
REQ-023 In IDLE, burst_start with 1 <= burst_len <= DEPTH and burst_addr < DEPTH SHALL load the pointer and remaining count, then go to BURST.
REQ-024 Any other burst_start SHALL set err and stay in IDLE.
REQ-025 burst_start SHALL take priority over commit in the same cycle, and the commit SHALL be held pending.
REQ-026 In BURST: wr_ready = en; wr_addr is ignored; each accepted beat writes shadow[pointer], increments the pointer with wrap DEPTH-1 -> 0, and decrements the count.
REQ-027 On the last accepted beat of a burst, the FSM SHALL return to IDLE and done SHALL pulse high for exactly the following cycle.
REQ-028 burst_start during BURST SHALL be ignored without setting err.
REQ-029 commit in IDLE SHALL enter COMMIT; the copy active <= shadow SHALL occur at that same edge, so outputs change one cycle after commit is sampled.
REQ-030 COMMIT SHALL last exactly one cycle with wr_ready = 0, then return to IDLE.
REQ-031 commit during BURST SHALL set a pending flag; on burst completion the FSM SHALL go to COMMIT instead of IDLE (done still pulses), and the flag SHALL clear at the copy.
REQ-032 err SHALL be sticky until err_clr; if err_clr and a new error occur in the same cycle, the set SHALL win.
REQ-033 en low SHALL freeze the burst state (pointer and count) without aborting the burst.

Reset
REQ-034 rst high SHALL asynchronously force all shadow and active registers to 0, state to IDLE, pointer, count, pending, done and err to 0, and wr_ready to 0 while rst is asserted.
REQ-035 Reset mid-burst or mid-commit SHALL abandon the operation with no partial copy retained.

Verification
REQ-036 Defaults (DEPTH=24): single write addr 6 = 0x5A -> win[ch1,w0] stays 0; after commit it reads 0x5A, one cycle after commit.
REQ-037 Burst addr 22, len 4, data 1,2,3,4 -> shadow addresses 22,23,0,1 written; done high one cycle after the 4th beat.
REQ-038 commit pulsed mid-burst -> no output change until the burst ends; COMMIT follows done; outputs update afterwards.
REQ-039 Write 0xFF to addr 5 (ch0 sign) and commit -> sign[0] = 1; single write to addr 24 -> err = 1, no register change; err_clr -> err = 0.
REQ-040 Burst with len 0 -> err = 1, busy stays 0; en low mid-burst -> wr_ready = 0 and pointer held.
REQ-041 rst asserted after 2 of 4 burst beats -> all outputs 0, busy 0; a following burst starts cleanly.
